// File: rtl/pong_game.sv
// pong_game: pixel-stage Pong for a 640x480 VGA timing generator.
//
// Game state (paddles, ball, scores, SERVE/PLAY/OVER control) advances once
// per frame on frame_tick (y == V_ACTIVE, x == 0), so positions are stable
// for the whole visible frame. Each cycle the current (x, y, de) is rendered
// to a registered RRGGBB colour, and the syncs are registered alongside it
// so colour and syncs leave on the same clock.
//
// Ports:
//   clk, rst_n                      pixel clock, async active-low reset
//   x, y, de                        pixel coordinate and active-video flag
//   hsync_in, vsync_in              syncs from the timing generator
//   btn_l_up/dn, btn_r_up/dn        asynchronous active-high paddle buttons
//   rgb                             {R[1:0], G[1:0], B[1:0]}, 1 cycle latency
//   hsync_o, vsync_o                syncs delayed to match rgb
//   score_l, score_r                binary scores
//
// Build option: define PONG_AI_EN to drive the right paddle from the ball
// position instead of btn_r_* (those buttons still release OVER).
module pong_game #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned LP_X         = 16,
  parameter int unsigned RP_X         = 616,
  parameter int unsigned PADDLE_STEP  = 4,
  parameter int unsigned BALL_STEP    = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       de,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [5:0] rgb,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [3:0] score_l,
  output logic [3:0] score_r
);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_e;

  // 11-bit copies so sums that can pass 1023 never wrap.
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] PW = 11'(PADDLE_W);
  localparam logic [10:0] PH = 11'(PADDLE_H);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] PS = 11'(PADDLE_STEP);
  localparam logic [10:0] BST = 11'(BALL_STEP);
  localparam logic [10:0] LPX = 11'(LP_X);
  localparam logic [10:0] RPX = 11'(RP_X);

  localparam logic [9:0] BX0     = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BY0     = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] PY0     = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] PY_MAX  = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] BY_MAX  = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] BX_LHIT = 10'(LP_X + PADDLE_W);
  localparam logic [9:0] BX_RHIT = 10'(RP_X - BALL_SIZE);
  localparam logic [9:0] NET_X0  = 10'(H_ACTIVE / 2 - 2);
  localparam logic [9:0] NET_X1  = 10'(H_ACTIVE / 2 + 1);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);

  // {l_up, l_dn, r_up, r_dn}
  logic [3:0] btn_meta_q, btn_sync_q;
  state_e     state_q, state_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic [9:0] bx_q, bx_d, by_q, by_d, lp_y_q, lp_y_d, rp_y_q, rp_y_d;
  logic       dx_q, dx_d, dy_q, dy_d;               // 1 = right / down
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [5:0] rgb_q, rgb_d;
  logic       hsync_q, vsync_q;

  logic       frame_tick;
  logic [9:0] bx_mv, by_mv, lp_y_mv, rp_y_mv;
  logic       dx_mv, dy_mv, miss_l, miss_r;

  assign frame_tick = (y == 10'(V_ACTIVE)) && (x == '0);

  function automatic logic [9:0] paddle_next(input logic [9:0] py, input logic up,
                                             input logic dn);
    paddle_next = py;
    if (up && !dn)
      paddle_next = (11'(py) >= PS) ? py - 10'(PADDLE_STEP) : '0;
    else if (dn && !up)
      paddle_next = (11'(py) + PS > 11'(PY_MAX)) ? PY_MAX : py + 10'(PADDLE_STEP);
  endfunction

  function automatic logic overlap(input logic [9:0] ball_y, input logic [9:0] py);
    overlap = (11'(ball_y) + BS > 11'(py)) && (11'(ball_y) < 11'(py) + PH);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      btn_meta_q <= {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn};
      btn_sync_q <= btn_meta_q;
    end
  end

  assign lp_y_mv = paddle_next(lp_y_q, btn_sync_q[3], btn_sync_q[2]);

`ifdef PONG_AI_EN
  // Right paddle chases the ball centre; holds still within one step.
  logic [10:0] rp_ctr, ball_ctr;
  assign rp_ctr   = 11'(rp_y_q) + PH / 11'd2;
  assign ball_ctr = 11'(by_q) + BS / 11'd2;
  always_comb begin
    rp_y_mv = rp_y_q;
    if (ball_ctr > rp_ctr + PS)      rp_y_mv = paddle_next(rp_y_q, 1'b0, 1'b1);
    else if (ball_ctr + PS < rp_ctr) rp_y_mv = paddle_next(rp_y_q, 1'b1, 1'b0);
  end
`else
  assign rp_y_mv = paddle_next(rp_y_q, btn_sync_q[1], btn_sync_q[0]);
`endif

  // Candidate ball move for a PLAY tick; both axes resolve independently.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    by_mv  = by_q;
    dy_mv  = dy_q;
    bx_mv  = bx_q;
    dx_mv  = dx_q;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (!dy_q) begin
      if (11'(by_q) < BST) begin by_mv = '0; dy_mv = 1'b1; end
      else by_mv = by_q - 10'(BALL_STEP);
    end else begin
      if (11'(by_q) + BS + BST > VA) begin by_mv = BY_MAX; dy_mv = 1'b0; end
      else by_mv = by_q + 10'(BALL_STEP);
    end
    // Paddle bounce is tested before the miss so it wins.
    if (!dx_q) begin
      if (11'(bx_q) <= LPX + PW && overlap(by_q, lp_y_q)) begin
        bx_mv = BX_LHIT; dx_mv = 1'b1;
      end else if (11'(bx_q) < BST) miss_r = 1'b1;
      else bx_mv = bx_q - 10'(BALL_STEP);
    end else begin
      if (11'(bx_q) + BS >= RPX && overlap(by_q, rp_y_q)) begin
        bx_mv = BX_RHIT; dx_mv = 1'b0;
      end else if (11'(bx_q) + BS + BST > HA) miss_l = 1'b1;
      else bx_mv = bx_q + 10'(BALL_STEP);
    end
  end

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    lp_y_d      = lp_y_q;
    rp_y_d      = rp_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    if (frame_tick) begin
      unique case (state_q)
        SERVE: begin
          if (serve_cnt_q == SERVE_LAST) begin
            serve_cnt_d = '0;
            state_d     = PLAY;
          end else serve_cnt_d = serve_cnt_q + 8'd1;
        end
        PLAY: begin
          bx_d = bx_mv; by_d = by_mv; dx_d = dx_mv; dy_d = dy_mv;
          if (miss_r) begin
            score_r_d = score_r_q + 4'd1;
            dx_d      = 1'b0;
            bx_d      = BX0;
            by_d      = BY0;
            state_d   = (score_r_d == WIN) ? OVER : SERVE;
          end else if (miss_l) begin
            score_l_d = score_l_q + 4'd1;
            dx_d      = 1'b1;
            bx_d      = BX0;
            by_d      = BY0;
            state_d   = (score_l_d == WIN) ? OVER : SERVE;
          end
        end
        OVER: begin
          if (|btn_sync_q) begin
            score_l_d = '0;
            score_r_d = '0;
            state_d   = SERVE;
          end
        end
        default: state_d = SERVE;
      endcase
      if (state_q != OVER) begin
        lp_y_d = lp_y_mv;
        rp_y_d = rp_y_mv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SERVE;
      serve_cnt_q <= '0;
      bx_q        <= BX0;
      by_q        <= BY0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      lp_y_q      <= PY0;
      rp_y_q      <= PY0;
      score_l_q   <= '0;
      score_r_q   <= '0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      lp_y_q      <= lp_y_d;
      rp_y_q      <= rp_y_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
    end
  end

  // Render in priority order: blanking, ball, paddles, dashed centre net.
  always_comb begin
    rgb_d = 6'b000000;
    if (de) begin
      if (11'(x) >= 11'(bx_q) && 11'(x) < 11'(bx_q) + BS &&
          11'(y) >= 11'(by_q) && 11'(y) < 11'(by_q) + BS)
        rgb_d = 6'b111111;
      else if ((11'(x) >= LPX && 11'(x) < LPX + PW &&
                11'(y) >= 11'(lp_y_q) && 11'(y) < 11'(lp_y_q) + PH) ||
               (11'(x) >= RPX && 11'(x) < RPX + PW &&
                11'(y) >= 11'(rp_y_q) && 11'(y) < 11'(rp_y_q) + PH))
        rgb_d = 6'b111111;
      else if (x >= NET_X0 && x <= NET_X1 && !y[3])
        rgb_d = 6'b010101;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
    end
  end

  assign rgb     = rgb_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_pong_game.sv
// Directed bench for pong_game. Frames are compressed: each tick() idles a few
// cycles off the visible area, then presents (x=0, y=480) for one cycle.
// Ball trajectories below are worked out by hand from the start position.
module tb_pong_game;

  localparam int S_SERVE = 0;
  localparam int S_PLAY  = 1;
  localparam int S_OVER  = 2;
  localparam int PT      = 219;   // ticks per point: 60 serve + 159 flight

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x, y;
  logic       de, hsync_in, vsync_in;
  logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
  logic [5:0] rgb;
  logic       hsync_o, vsync_o;
  logic [3:0] score_l, score_r;

  int n_cmp  = 0;
  int n_fail = 0;
  int tick_n = 0;
  int t0     = 0;

  always #5 clk = ~clk;

  pong_game dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .de       (de),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .btn_l_up (btn_l_up),
    .btn_l_dn (btn_l_dn),
    .btn_r_up (btn_r_up),
    .btn_r_dn (btn_r_dn),
    .rgb      (rgb),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o),
    .score_l  (score_l),
    .score_r  (score_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    x = 10'd10; y = 10'd481; de = 1'b0;
    cyc(3);
    x = 10'd0; y = 10'd480;
    cyc(1);
    x = 10'd10; y = 10'd481;
    tick_n++;
  endtask

  task automatic run_to(input int n);
    while (tick_n < n) tick();
  endtask

  task automatic pixel(input string tag, input int px, input int py, input logic pde,
                       input logic [5:0] exp);
    x = 10'(px); y = 10'(py); de = pde;
    cyc(1);
    check(tag, 32'(rgb), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    x = '0; y = '0; de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    cyc(2);

    // Reset state
    check("rst_rgb", 32'(rgb), 0);
    check("rst_hsync", 32'(hsync_o), 0);
    check("rst_vsync", 32'(vsync_o), 0);
    check("rst_score_l", 32'(score_l), 0);
    check("rst_score_r", 32'(score_r), 0);
    check("rst_state", 32'(dut.state_q), S_SERVE);
    check("rst_bx", 32'(dut.bx_q), 316);
    check("rst_by", 32'(dut.by_q), 236);
    check("rst_lp", 32'(dut.lp_y_q), 208);
    check("rst_rp", 32'(dut.rp_y_q), 208);
    rst_n = 1'b1;
    cyc(1);

    // Render and sync alignment
    pixel("px_net", 320, 0, 1'b1, 6'b010101);
    pixel("px_net_lo", 318, 0, 1'b1, 6'b010101);
    pixel("px_net_gap", 320, 8, 1'b1, 6'b000000);
    pixel("px_net_right", 322, 0, 1'b1, 6'b000000);
    pixel("px_net_left", 317, 0, 1'b1, 6'b000000);
    pixel("px_ball", 316, 236, 1'b1, 6'b111111);
    pixel("px_paddle_l", 16, 208, 1'b1, 6'b111111);
    pixel("px_paddle_r", 623, 271, 1'b1, 6'b111111);
    pixel("px_below_paddle", 16, 272, 1'b1, 6'b000000);
    pixel("px_de_low", 316, 236, 1'b0, 6'b000000);
    hsync_in = 1'b1; vsync_in = 1'b0;
    cyc(1);
    check("hsync_delay", 32'(hsync_o), 1);
    check("vsync_delay", 32'(vsync_o), 0);
    hsync_in = 1'b0; vsync_in = 1'b1;
    #2;
    check("hsync_held", 32'(hsync_o), 1);
    cyc(1);
    check("hsync_fall", 32'(hsync_o), 0);
    check("vsync_rise", 32'(vsync_o), 1);
    vsync_in = 1'b0;

    // Serve hold and paddle limits
    btn_l_up = 1'b1; btn_l_dn = 1'b1; btn_r_up = 1'b1;
    run_to(2);
    check("lp_both_hold", 32'(dut.lp_y_q), 208);
    btn_l_dn = 1'b0;
    run_to(53);
    check("lp_one_step_left", 32'(dut.lp_y_q), 4);
    run_to(54);
    check("lp_top", 32'(dut.lp_y_q), 0);
    check("rp_top", 32'(dut.rp_y_q), 0);
    run_to(59);
    check("serve_cnt59", 32'(dut.serve_cnt_q), 59);
    check("state_serve59", 32'(dut.state_q), S_SERVE);
    check("bx_serve59", 32'(dut.bx_q), 316);
    run_to(60);
    check("state_play60", 32'(dut.state_q), S_PLAY);
    check("bx_tick60", 32'(dut.bx_q), 316);
    check("by_tick60", 32'(dut.by_q), 236);
    run_to(61);
    check("bx_tick61", 32'(dut.bx_q), 318);
    check("by_tick61", 32'(dut.by_q), 238);
    run_to(62);
    check("lp_stays_top", 32'(dut.lp_y_q), 0);
    btn_l_up = 1'b0;

    // Nine right-side misses; right paddle parked away from the ball's path
    for (int p = 1; p <= 9; p++) begin
      btn_r_up = (p % 2 == 1);
      btn_r_dn = (p % 2 == 0);
      run_to(PT * (p - 1) + 120);
      btn_r_up = 1'b0; btn_r_dn = 1'b0;
      if (p == 2) begin
        run_to(397);
        check("by_to_top", 32'(dut.by_q), 0);
        run_to(398);
        check("by_top_hold", 32'(dut.by_q), 0);
        check("dy_down", 32'(dut.dy_q), 1);
        run_to(399);
        check("by_after_top", 32'(dut.by_q), 2);
      end
      run_to(PT * p - 1);
      check($sformatf("score_l_pre%0d", p), 32'(score_l), 32'(p - 1));
      check($sformatf("state_pre%0d", p), 32'(dut.state_q), S_PLAY);
      run_to(PT * p);
      check($sformatf("score_l_pt%0d", p), 32'(score_l), 32'(p));
      check($sformatf("state_pt%0d", p), 32'(dut.state_q), (p == 9) ? S_OVER : S_SERVE);
      check($sformatf("bx_recentre%0d", p), 32'(dut.bx_q), 316);
      check($sformatf("by_recentre%0d", p), 32'(dut.by_q), 236);
    end

    // OVER: waits for a button, paddles frozen
    tick();
    check("over_hold", 32'(dut.state_q), S_OVER);
    check("over_score_l", 32'(score_l), 9);
    btn_l_dn = 1'b1;
    tick();
    check("over_exit_state", 32'(dut.state_q), S_SERVE);
    check("over_exit_score_l", 32'(score_l), 0);
    check("over_exit_score_r", 32'(score_r), 0);
    check("over_lp_frozen", 32'(dut.lp_y_q), 0);
    btn_l_dn = 1'b0;
    t0 = tick_n;

    // Rally: right bounce, left bounce, right bounce, left miss
    btn_l_dn = 1'b1;
    run_to(t0 + 71);
    btn_l_dn = 1'b0;
    check("lp_284", 32'(dut.lp_y_q), 284);
    run_to(t0 + 206);
    check("bx_608_right", 32'(dut.bx_q), 608);
    check("dx_right_606", 32'(dut.dx_q), 1);
    run_to(t0 + 207);
    check("bx_rbounce", 32'(dut.bx_q), 608);
    check("dx_rbounce", 32'(dut.dx_q), 0);
    btn_r_dn = 1'b1;
    run_to(t0 + 277);
    btn_r_dn = 1'b0;
    check("rp_280", 32'(dut.rp_y_q), 280);
    run_to(t0 + 499);
    check("bx_24_left", 32'(dut.bx_q), 24);
    check("dx_left_24", 32'(dut.dx_q), 0);
    run_to(t0 + 500);
    check("bx_lbounce", 32'(dut.bx_q), 24);
    check("dx_lbounce", 32'(dut.dx_q), 1);
    check("by_lbounce", 32'(dut.by_q), 304);
    run_to(t0 + 501);
    check("bx_after_lbounce", 32'(dut.bx_q), 26);
    run_to(t0 + 793);
    check("bx_rbounce2", 32'(dut.bx_q), 608);
    check("dx_rbounce2", 32'(dut.dx_q), 0);
    run_to(t0 + 1097);
    check("bx_edge", 32'(dut.bx_q), 0);
    check("score_r_pre", 32'(score_r), 0);
    check("state_pre_lmiss", 32'(dut.state_q), S_PLAY);
    run_to(t0 + 1098);
    check("score_r_pt", 32'(score_r), 1);
    check("score_l_after_lmiss", 32'(score_l), 0);
    check("state_lmiss", 32'(dut.state_q), S_SERVE);
    check("bx_lmiss_recentre", 32'(dut.bx_q), 316);
    check("dx_lmiss", 32'(dut.dx_q), 0);

    // Asynchronous reset mid-frame
    x = 10'd320; y = 10'd0; de = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", 32'(rgb), 0);
    check("mid_rst_score_r", 32'(score_r), 0);
    check("mid_rst_lp", 32'(dut.lp_y_q), 208);
    check("mid_rst_rp", 32'(dut.rp_y_q), 208);
    check("mid_rst_dx", 32'(dut.dx_q), 1);
    check("mid_rst_state", 32'(dut.state_q), S_SERVE);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
